// File: rtl/serial_frame_tx.sv
// Bit-serial frame transmitter: start bit, DATA_W data bits LSB-first,
// optional even-parity bit, stop bit. Each bit is held for BIT_TICKS cycles.
module serial_frame_tx #(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1,
  parameter int BIT_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int TICK_W = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_shreg, w_shreg_nxt;
  logic                r_par, w_par_nxt;
  logic [BIT_W-1:0]    r_bit_cnt, w_bit_cnt_nxt;
  logic [TICK_W-1:0]   r_tick_cnt, w_tick_cnt_nxt;
  logic                r_out, r_busy, r_done, r_in_ready;
  logic                w_out_nxt, w_done_nxt, w_tick_last;

  assign out      = r_out;
  assign busy     = r_busy;
  assign done     = r_done;
  assign in_ready = r_in_ready;

  // Next-state, datapath and next-output decode.
  always_comb begin
    w_state_nxt    = r_state;
    w_shreg_nxt    = r_shreg;
    w_par_nxt      = r_par;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_tick_cnt_nxt = r_tick_cnt;
    w_done_nxt     = 1'b0;
    w_out_nxt      = 1'b1;
    w_tick_last    = (r_tick_cnt == TICK_LAST);

    if (r_state == S_IDLE) begin
      w_tick_cnt_nxt = '0;
    end else if (w_tick_last) begin
      w_tick_cnt_nxt = '0;
    end else begin
      w_tick_cnt_nxt = r_tick_cnt + 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_shreg_nxt   = in_data;
          w_par_nxt     = even_parity(in_data);
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_START;
        end else begin
          w_state_nxt   = S_IDLE;
        end
      end
      S_START: begin
        if (w_tick_last) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_START;
        end
      end
      S_DATA: begin
        if (w_tick_last) begin
          w_shreg_nxt = r_shreg >> 1;
          if (r_bit_cnt == BIT_LAST) begin
            w_bit_cnt_nxt = '0;
            w_state_nxt   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          end
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      S_PARITY: begin
        if (w_tick_last) begin
          w_state_nxt = S_STOP;
        end else begin
          w_state_nxt = S_PARITY;
        end
      end
      S_STOP: begin
        if (w_tick_last) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_state_nxt = S_STOP;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    // Line level is derived from the upcoming state so out stays registered.
    case (w_state_nxt)
      S_START:  w_out_nxt = 1'b0;
      S_DATA:   w_out_nxt = w_shreg_nxt[0];
      S_PARITY: w_out_nxt = w_par_nxt;
      default:  w_out_nxt = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_par      <= 1'b0;
      r_bit_cnt  <= '0;
      r_tick_cnt <= '0;
      r_out      <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_in_ready <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_shreg    <= w_shreg_nxt;
      r_par      <= w_par_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_out      <= w_out_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
      r_in_ready <= (w_state_nxt == S_IDLE);
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed bench for serial_frame_tx: one instance with parity and single-cycle
// bits, one without parity and three-cycle bits.
module tb_serial_frame_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, a_out, a_busy, a_done;
  logic       b_ready, b_out, b_busy, b_done;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  serial_frame_tx #(.DATA_W(8), .PARITY_EN(1), .BIT_TICKS(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid),
    .in_ready(a_ready), .out(a_out), .busy(a_busy), .done(a_done)
  );

  serial_frame_tx #(.DATA_W(8), .PARITY_EN(0), .BIT_TICKS(3)) dut_b (
    .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid),
    .in_ready(b_ready), .out(b_out), .busy(b_busy), .done(b_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the falling edge inside the start-bit cycle; returns at the
  // falling edge of the cycle in which done should be high.
  task automatic run_frame_a(input logic [7:0] d, input logic p, input string tag);
    logic e;
    for (int i = 0; i < 11; i++) begin
      if (i == 0)      e = 1'b0;
      else if (i <= 8) e = d[i-1];
      else if (i == 9) e = p;
      else             e = 1'b1;
      chk($sformatf("%s_out%0d", tag, i), {31'd0, a_out}, {31'd0, e});
      chk($sformatf("%s_busy%0d", tag, i), {29'd0, a_busy, a_ready, a_done}, {29'd0, 3'b100});
      @(negedge clk);
    end
    chk($sformatf("%s_end", tag), {28'd0, a_done, a_busy, a_ready, a_out}, {28'd0, 4'b1011});
  endtask

  initial begin
    rst     = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    a_data  = 8'h00;
    b_data  = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_a", {28'd0, a_done, a_busy, a_ready, a_out}, {28'd0, 4'b0011});
    chk("reset_b", {28'd0, b_done, b_busy, b_ready, b_out}, {28'd0, 4'b0011});

    // 1: 0xA5, parity 0
    a_valid = 1'b1; a_data = 8'hA5;
    @(negedge clk);
    a_valid = 1'b0; a_data = 8'hxx;
    run_frame_a(8'hA5, 1'b0, "t1");
    @(negedge clk);
    chk("t1_done_once", {30'd0, a_done, a_out}, {30'd0, 2'b01});

    // 2: 0x01 (parity 1) then 0x00 (parity 0)
    a_valid = 1'b1; a_data = 8'h01;
    @(negedge clk);
    a_valid = 1'b0;
    run_frame_a(8'h01, 1'b1, "t2a");
    @(negedge clk);
    a_valid = 1'b1; a_data = 8'h00;
    @(negedge clk);
    a_valid = 1'b0;
    run_frame_a(8'h00, 1'b0, "t2b");
    @(negedge clk);

    // 3: BIT_TICKS=3, no parity, 0x80 -> 24 zeros then 6 ones
    b_valid = 1'b1; b_data = 8'h80;
    @(negedge clk);
    b_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      chk($sformatf("t3_out%0d", i), {31'd0, b_out}, (i < 24) ? 32'd0 : 32'd1);
      chk($sformatf("t3_busy%0d", i), {30'd0, b_busy, b_done}, {30'd0, 2'b10});
      @(negedge clk);
    end
    chk("t3_end", {28'd0, b_done, b_busy, b_ready, b_out}, {28'd0, 4'b1011});
    @(negedge clk);
    chk("t3_done_once", {31'd0, b_done}, 32'd0);

    // 4: valid held high, 0x3C then 0xC3 back to back
    a_valid = 1'b1; a_data = 8'h3C;
    @(negedge clk);
    a_data = 8'hC3;
    run_frame_a(8'h3C, 1'b0, "t4a");
    @(negedge clk);
    a_valid = 1'b0;
    run_frame_a(8'hC3, 1'b0, "t4b");
    @(negedge clk);
    chk("t4_idle", {29'd0, a_done, a_busy, a_out}, {29'd0, 3'b001});

    // 5: reset during data bit 4 of 0x0F
    a_valid = 1'b1; a_data = 8'h0F;
    @(negedge clk);
    a_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("t5_bit4", {30'd0, a_out, a_busy}, {30'd0, 2'b01});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_abort", {28'd0, a_done, a_busy, a_ready, a_out}, {28'd0, 4'b0011});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("t5_nodone%0d", i), {30'd0, a_done, a_out}, {30'd0, 2'b01});
    end
    a_valid = 1'b1; a_data = 8'h5A;
    @(negedge clk);
    a_valid = 1'b0;
    run_frame_a(8'h5A, 1'b0, "t5");
    @(negedge clk);

    // 6: data changes after acceptance
    a_valid = 1'b1; a_data = 8'hFF;
    @(negedge clk);
    a_valid = 1'b0; a_data = 8'h00;
    run_frame_a(8'hFF, 1'b0, "t6");
    @(negedge clk);
    chk("t6_idle", {30'd0, a_done, a_out}, {30'd0, 2'b01});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Bit-serial frame transmitter: accepts a parallel word over a valid/ready handshake and shifts it out on one wire.
- Frame format: start bit, data LSB-first, optional even-parity bit, stop bit.
- It is the sending end of the single-wire byte link, and pairs with the serial frame receiver on the far side.
- Parity is the XOR-reduction of the data word, matching the XOR gate primitive.

Parameters:
DATA_W, 8, data bits per frame (1..32)
PARITY_EN, 1, 1 = insert even-parity bit after data; 0 = no parity bit
BIT_TICKS, 1, clock cycles each serial bit is held (1..65535)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_data  input  DATA_W  word to send; sampled only on handshake
in_valid  input  1  producer has a word
in_ready  output  1  transmitter can accept a word; high only in IDLE
out  output  1  serial line; idles high
busy  output  1  frame in progress (any state but IDLE)
done  output  1  one-cycle pulse when the stop bit completes

Behaviour:
- All outputs are registered.
- Reset (rst=1 at a clock edge): state=IDLE, out=1, busy=0, done=0, in_ready=1, shift register and counters cleared.
- Reset mid-frame aborts the frame immediately: out returns to 1 on the next cycle and no done pulse is generated.
- States: IDLE -> START -> DATA -> PARITY (only if PARITY_EN) -> STOP -> IDLE.
- Handshake: accept occurs on a clock edge where in_valid & in_ready. in_data is latched into the shift register; parity=^in_data is latched; state goes to START.
- in_valid while not in_ready is ignored. in_data changes after acceptance have no effect on the frame.
- Latency: the cycle after the accept edge, out=0 (start bit) and busy=1.
- Bit timing: each state holds out for exactly BIT_TICKS cycles, using a tick counter that runs 0..BIT_TICKS-1. The state advances when the counter reaches BIT_TICKS-1.
- DATA: out=shreg[0]; the register shifts right once per bit period; a bit counter runs 0..DATA_W-1.
- PARITY: out = latched parity (even: the total number of ones in data+parity is even).
- STOP: out=1.
- On the edge that ends STOP: state=IDLE, and in the following cycle done=1 for exactly one cycle, in_ready=1, busy=0.
- Back-to-back frames: a word can be accepted in the first IDLE cycle, the same cycle done is high. Between frames there is therefore exactly one idle-high cycle minimum beyond the stop bit.
- Frame length, start bit first cycle to stop bit last cycle: (2 + DATA_W + PARITY_EN) * BIT_TICKS cycles.
- Counter widths:
  - bit counter: clog2(DATA_W) bits, at least 1.
  - tick counter: clog2(BIT_TICKS) bits, at least 1.
  - Neither counter wraps past its terminal count.
- X on in_data while in_valid=0 must not propagate to out.

Test Plan:
1. Reset, then DATA_W=8, PARITY_EN=1, BIT_TICKS=1, send 0xA5 -> out per cycle: 0,1,0,1,0,0,1,0,1,0,1, then idle 1. done high 1 cycle after stop; busy high for 11 cycles.
2. Same config, send 0x01 -> out per cycle: 0,1,0,0,0,0,0,0,0,1(parity),1. Then send 0x00 -> parity bit 0.
3. BIT_TICKS=3, PARITY_EN=0, send 0x80 -> every bit held 3 cycles: 3×0 start, 21×0 for bits 0..6, 3×1 for bit 7, 3×1 stop. Total frame 30 cycles.
4. in_valid held high continuously with 0x3C then 0xC3 -> two frames separated by exactly one idle cycle. in_valid ignored while busy; 0xC3 accepted in the cycle done=1.
5. Assert rst during DATA bit 4 -> next cycle out=1, busy=0, in_ready=1, no done pulse. A new word 0x5A then transmits a correct full frame.
6. Change in_data mid-frame from 0xFF to 0x00 after accepting 0xFF -> frame carries eight 1s and parity 0, unaffected by the change.
